// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// instruction_fetch_unit
//
// Instruction fetch stage of the RV32IM pipeline. It owns the program counter
// and issues word reads to instruction memory over a busywait handshake.
// Returned instructions are buffered and presented to the IF/ID register
// together with their PC, PC+4 and a valid flag. It honours hazard stalls and
// redirects from the branch unit. When no real instruction is available, a
// NOP bubble (addi x0,x0,0) is shown instead.
//
// Parameters:
//   RESET_PC       first fetch address after reset (bits [1:0] forced to 0)
//   NOP_INSTR      encoding driven on INSTRUCTION when FETCH_VALID=0
//
// Ports:
//   CLK            clock, all state changes on the rising edge
//   RESET          synchronous, active-high reset
//   STALL          hazard unit holds IF/ID; the output buffer must not advance
//   BRANCH_TAKEN   one-cycle redirect request from EX
//   BRANCH_TARGET  redirect address (bits [1:0] ignored)
//   IMEM_READ      read request to instruction memory (depends on FSM only)
//   IMEM_ADDRESS   word address of the request (always equals the fetch PC)
//   IMEM_READDATA  read data, valid when IMEM_READ=1 and IMEM_BUSYWAIT=0
//   IMEM_BUSYWAIT  memory not ready
//   INSTRUCTION    buffered instruction (registered)
//   PC             address of INSTRUCTION (registered)
//   PC_PLUS_4      PC+4 modulo 2^32 (registered)
//   FETCH_VALID    outputs hold a real instruction (registered)
// ============================================================================
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS_4,
  output logic        FETCH_VALID
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_pc4_q, out_pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        skid_valid_q, skid_valid_d;

  logic [31:0] pc_inc;
  logic [31:0] skid_pc_inc;
  logic        completion;
  logic        buffer_blocked;
  logic        unused_target_bits;

  // Natural 32-bit wrap: 0xFFFFFFFC + 4 = 0.
  assign pc_inc      = pc_q + 32'd4;
  assign skid_pc_inc = skid_pc_q + 32'd4;

  assign completion     = (state_q == REQ) && !IMEM_BUSYWAIT;
  assign buffer_blocked = valid_q && STALL;

  // Target is word-aligned by construction; the low bits are dropped.
  assign unused_target_bits = ^BRANCH_TARGET[1:0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    out_pc_d     = out_pc_q;
    out_pc4_d    = out_pc4_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;

    if (BRANCH_TAKEN) begin
      // Redirect wins over stall and drops any completion at this edge. The
      // trip through IDLE gives memory one cycle to forget the old request.
      pc_d         = {BRANCH_TARGET[31:2], 2'b00};
      instr_d      = NOP_INSTR;
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
      state_d      = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = REQ;
        end

        REQ: begin
          if (completion) begin
            pc_d = pc_inc;
            if (!buffer_blocked) begin
              instr_d   = IMEM_READDATA;
              out_pc_d  = pc_q;
              out_pc4_d = pc_inc;
              valid_d   = 1'b1;
            end else begin
              // Downstream is holding a valid instruction, so park the new
              // one and stop requesting until the stall lifts.
              skid_instr_d = IMEM_READDATA;
              skid_pc_d    = pc_q;
              skid_valid_d = 1'b1;
              state_d      = HOLD;
            end
          end else if (!STALL) begin
            // Buffer was consumed and nothing replaces it: emit a bubble but
            // keep PC/PC_PLUS_4 pointing at the last real instruction.
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
        end

        HOLD: begin
          if (!STALL) begin
            instr_d      = skid_instr_q;
            out_pc_d     = skid_pc_q;
            out_pc4_d    = skid_pc_inc;
            valid_d      = skid_valid_q;
            skid_valid_d = 1'b0;
            state_d      = REQ;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC_ALIGNED;
      instr_q      <= NOP_INSTR;
      out_pc_q     <= 32'd0;
      out_pc4_q    <= 32'd0;
      valid_q      <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= 32'd0;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      out_pc_q     <= out_pc_d;
      out_pc4_q    <= out_pc4_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign IMEM_READ    = (state_q == REQ);
  assign IMEM_ADDRESS = pc_q;
  assign INSTRUCTION  = instr_q;
  assign PC           = out_pc_q;
  assign PC_PLUS_4    = out_pc4_q;
  assign FETCH_VALID  = valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// tb_instruction_fetch_unit
//
// Directed bench for instruction_fetch_unit. The main instance (RESET_PC=0)
// talks to a small memory model that returns 0xA0000000|addr and inserts a
// configurable number of busywait cycles per read. A second instance with
// RESET_PC=0xFFFFFFF8 and zero-wait memory exercises the address wrap.
// ============================================================================
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // Main instance signals
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_readdata;
  logic        imem_busywait;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic        fetch_valid;

  // Wrap instance signals
  logic        reset_w = 1'b1;
  logic        imem_read_w;
  logic [31:0] imem_address_w;
  logic [31:0] imem_readdata_w;
  logic [31:0] instruction_w;
  logic [31:0] pc_w;
  logic [31:0] pc_plus_4_w;
  logic        fetch_valid_w;

  // Memory model: busy for wait_cfg cycles of every request, then completes.
  int wait_cfg = 0;
  int busy_cnt = 0;

  assign imem_readdata   = 32'hA000_0000 | imem_address;
  assign imem_busywait   = imem_read && (busy_cnt < wait_cfg);
  assign imem_readdata_w = 32'hA000_0000 | imem_address_w;

  always @(posedge clk) begin
    if (!imem_read || !imem_busywait) busy_cnt <= 0;
    else                              busy_cnt <= busy_cnt + 1;
  end

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) u_dut (
    .CLK          (clk),
    .RESET        (reset),
    .STALL        (stall),
    .BRANCH_TAKEN (branch_taken),
    .BRANCH_TARGET(branch_target),
    .IMEM_READ    (imem_read),
    .IMEM_ADDRESS (imem_address),
    .IMEM_READDATA(imem_readdata),
    .IMEM_BUSYWAIT(imem_busywait),
    .INSTRUCTION  (instruction),
    .PC           (pc),
    .PC_PLUS_4    (pc_plus_4),
    .FETCH_VALID  (fetch_valid)
  );

  instruction_fetch_unit #(
    .RESET_PC (32'hFFFF_FFF8),
    .NOP_INSTR(32'h0000_0013)
  ) u_dut_wrap (
    .CLK          (clk),
    .RESET        (reset_w),
    .STALL        (1'b0),
    .BRANCH_TAKEN (1'b0),
    .BRANCH_TARGET(32'd0),
    .IMEM_READ    (imem_read_w),
    .IMEM_ADDRESS (imem_address_w),
    .IMEM_READDATA(imem_readdata_w),
    .IMEM_BUSYWAIT(1'b0),
    .INSTRUCTION  (instruction_w),
    .PC           (pc_w),
    .PC_PLUS_4    (pc_plus_4_w),
    .FETCH_VALID  (fetch_valid_w)
  );

  // Advance one rising edge and settle; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (fetch_valid !== 1'b0 || instruction !== NOP || pc !== 32'd0 ||
        pc_plus_4 !== 32'd0 || imem_read !== 1'b0 || imem_address !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_values: valid=%b instr=%h pc=%h pc4=%h rd=%b addr=%h, expected 0 %h 0 0 0 0",
               fetch_valid, instruction, pc, pc_plus_4, imem_read, imem_address, NOP);
    end
    reset = 1'b0;
    tick();  // E1: IDLE -> REQ
    checks++;
    if (imem_read !== 1'b1 || imem_address !== 32'd0 || fetch_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL startup_e1: rd=%b addr=%h valid=%b, expected 1 00000000 0",
               imem_read, imem_address, fetch_valid);
    end
    tick();  // E2: first instruction
    checks++;
    if (fetch_valid !== 1'b1 || pc !== 32'd0 || pc_plus_4 !== 32'd4 ||
        instruction !== 32'hA000_0000) begin
      errors++;
      $display("[TB] FAIL startup_e2: valid=%b pc=%h pc4=%h instr=%h, expected 1 00000000 00000004 a0000000",
               fetch_valid, pc, pc_plus_4, instruction);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_pc;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_pc = 32'(k * 4);
      checks++;
      if (fetch_valid !== 1'b1 || pc !== exp_pc || pc_plus_4 !== exp_pc + 32'd4 ||
          instruction !== (32'hA000_0000 | exp_pc)) begin
        errors++;
        $display("[TB] FAIL zero_wait_%0d: valid=%b pc=%h pc4=%h instr=%h, expected 1 %h %h %h",
                 k, fetch_valid, pc, pc_plus_4, instruction, exp_pc, exp_pc + 32'd4,
                 32'hA000_0000 | exp_pc);
      end
    end
  endtask

  task automatic test_busywait();
    logic [31:0] req_pc;
    logic [31:0] prev_pc;
    // Buffer holds 0x14; pending request is 0x18.
    wait_cfg = 2;
    prev_pc  = 32'h14;
    for (int r = 0; r < 3; r++) begin
      req_pc = 32'h18 + 32'(r * 4);
      for (int b = 0; b < 2; b++) begin
        tick();
        checks++;
        if (fetch_valid !== 1'b0 || instruction !== NOP || pc !== prev_pc ||
            imem_read !== 1'b1 || imem_address !== req_pc) begin
          errors++;
          $display("[TB] FAIL busy_bubble_%0d_%0d: valid=%b instr=%h pc=%h rd=%b addr=%h, expected 0 %h %h 1 %h",
                   r, b, fetch_valid, instruction, pc, imem_read, imem_address, NOP, prev_pc, req_pc);
        end
      end
      tick();
      checks++;
      if (fetch_valid !== 1'b1 || pc !== req_pc || instruction !== (32'hA000_0000 | req_pc)) begin
        errors++;
        $display("[TB] FAIL busy_complete_%0d: valid=%b pc=%h instr=%h, expected 1 %h %h",
                 r, fetch_valid, pc, instruction, req_pc, 32'hA000_0000 | req_pc);
      end
      prev_pc = req_pc;
    end
    wait_cfg = 0;
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();                                 // E1
    for (int k = 0; k < 5; k++) tick();     // E2..E6: PC 0x0..0x10
    checks++;
    if (pc !== 32'h10 || fetch_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_setup: pc=%h valid=%b, expected 00000010 1", pc, fetch_valid);
    end
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++;
      if (pc !== 32'h10 || fetch_valid !== 1'b1 || instruction !== 32'hA000_0010 ||
          imem_read !== 1'b0 || imem_address !== 32'h18) begin
        errors++;
        $display("[TB] FAIL stall_hold_%0d: pc=%h valid=%b instr=%h rd=%b addr=%h, expected 00000010 1 a0000010 0 00000018",
                 s, pc, fetch_valid, instruction, imem_read, imem_address);
      end
    end
    stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_pc = 32'h14 + 32'(k * 4);
      checks++;
      if (pc !== exp_pc || fetch_valid !== 1'b1 || instruction !== (32'hA000_0000 | exp_pc) ||
          pc_plus_4 !== exp_pc + 32'd4) begin
        errors++;
        $display("[TB] FAIL stall_release_%0d: pc=%h valid=%b instr=%h pc4=%h, expected %h 1 %h %h",
                 k, pc, fetch_valid, instruction, pc_plus_4, exp_pc, 32'hA000_0000 | exp_pc,
                 exp_pc + 32'd4);
      end
    end
  endtask

  task automatic test_redirect();
    // Buffer holds 0x1C; pending request 0x20 is stuck in busywait.
    wait_cfg = 100;
    stall    = 1'b1;
    tick();
    checks++;
    if (pc !== 32'h1C || fetch_valid !== 1'b1 || imem_address !== 32'h20) begin
      errors++;
      $display("[TB] FAIL redirect_pre: pc=%h valid=%b addr=%h, expected 0000001c 1 00000020",
               pc, fetch_valid, imem_address);
    end
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0102;
    tick();  // edge B
    branch_taken = 1'b0;
    stall        = 1'b0;
    wait_cfg     = 0;
    checks++;
    if (fetch_valid !== 1'b0 || instruction !== NOP || imem_read !== 1'b0 ||
        imem_address !== 32'h100) begin
      errors++;
      $display("[TB] FAIL redirect_b: valid=%b instr=%h rd=%b addr=%h, expected 0 %h 0 00000100",
               fetch_valid, instruction, imem_read, imem_address, NOP);
    end
    tick();  // B+1
    checks++;
    if (fetch_valid !== 1'b0 || imem_read !== 1'b1 || imem_address !== 32'h100) begin
      errors++;
      $display("[TB] FAIL redirect_b1: valid=%b rd=%b addr=%h, expected 0 1 00000100",
               fetch_valid, imem_read, imem_address);
    end
    tick();  // B+2
    checks++;
    if (fetch_valid !== 1'b1 || pc !== 32'h100 || instruction !== 32'hA000_0100 ||
        pc_plus_4 !== 32'h104) begin
      errors++;
      $display("[TB] FAIL redirect_b2: valid=%b pc=%h instr=%h pc4=%h, expected 1 00000100 a0000100 00000104",
               fetch_valid, pc, instruction, pc_plus_4);
    end
    tick();  // B+3
    checks++;
    if (fetch_valid !== 1'b1 || pc !== 32'h104) begin
      errors++;
      $display("[TB] FAIL redirect_b3: valid=%b pc=%h, expected 1 00000104", fetch_valid, pc);
    end
  endtask

  task automatic test_reset_in_hold();
    // Buffer holds 0x104; completion of 0x108 under stall goes to HOLD.
    stall = 1'b1;
    tick();
    checks++;
    if (imem_read !== 1'b0 || pc !== 32'h104 || fetch_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_entry: rd=%b pc=%h valid=%b, expected 0 00000104 1",
               imem_read, pc, fetch_valid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    stall = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || instruction !== NOP || pc !== 32'd0 || pc_plus_4 !== 32'd0 ||
        imem_read !== 1'b0 || imem_address !== 32'd0) begin
      errors++;
      $display("[TB] FAIL hold_reset: valid=%b instr=%h pc=%h pc4=%h rd=%b addr=%h, expected 0 %h 0 0 0 0",
               fetch_valid, instruction, pc, pc_plus_4, imem_read, imem_address, NOP);
    end
    tick();
    checks++;
    if (imem_read !== 1'b1 || imem_address !== 32'd0 || fetch_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_restart_req: rd=%b addr=%h valid=%b, expected 1 00000000 0",
               imem_read, imem_address, fetch_valid);
    end
    tick();
    checks++;
    if (fetch_valid !== 1'b1 || pc !== 32'd0 || instruction !== 32'hA000_0000) begin
      errors++;
      $display("[TB] FAIL hold_restart_first: valid=%b pc=%h instr=%h, expected 1 00000000 a0000000",
               fetch_valid, pc, instruction);
    end
    tick();
    checks++;
    if (fetch_valid !== 1'b1 || pc !== 32'd4) begin
      errors++;
      $display("[TB] FAIL hold_restart_second: valid=%b pc=%h, expected 1 00000004",
               fetch_valid, pc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_pc4 [3];
    exp_pc[0]  = 32'hFFFF_FFF8;  exp_pc4[0] = 32'hFFFF_FFFC;
    exp_pc[1]  = 32'hFFFF_FFFC;  exp_pc4[1] = 32'h0000_0000;
    exp_pc[2]  = 32'h0000_0000;  exp_pc4[2] = 32'h0000_0004;
    reset_w = 1'b1;
    tick();
    checks++;
    if (fetch_valid_w !== 1'b0 || imem_read_w !== 1'b0 || imem_address_w !== 32'hFFFF_FFF8) begin
      errors++;
      $display("[TB] FAIL wrap_reset: valid=%b rd=%b addr=%h, expected 0 0 fffffff8",
               fetch_valid_w, imem_read_w, imem_address_w);
    end
    reset_w = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (fetch_valid_w !== 1'b1 || pc_w !== exp_pc[k] || pc_plus_4_w !== exp_pc4[k] ||
          instruction_w !== (32'hA000_0000 | exp_pc[k])) begin
        errors++;
        $display("[TB] FAIL wrap_%0d: valid=%b pc=%h pc4=%h instr=%h, expected 1 %h %h %h",
                 k, fetch_valid_w, pc_w, pc_plus_4_w, instruction_w, exp_pc[k], exp_pc4[k],
                 32'hA000_0000 | exp_pc[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_busywait();
    test_stall();
    test_redirect();
    test_reset_in_hold();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage of the RV32IM pipeline. It owns the program counter and issues word reads to instruction memory using a busywait handshake. It buffers returned instructions and presents INSTRUCTION / PC / PC_PLUS_4 with a valid flag to the IF/ID pipeline register. It honours hazard stalls and redirects from the branch unit in EX, and inserts NOP bubbles whenever no valid instruction is available.

## Interface
- RESET_PC, 32'h00000000, PC fetched first after reset (bits [1:0] must be 0)
- NOP_INSTR, 32'h00000013, encoding driven on INSTRUCTION when no valid instruction (addi x0,x0,0)

- CLK  in  1  clock, all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- STALL  in  1  hazard unit: IF/ID holds; buffer must not advance
- BRANCH_TAKEN  in  1  one-cycle redirect request from EX
- BRANCH_TARGET  in  32  redirect address; bits [1:0] ignored (forced 00)
- IMEM_READ  out  1  read request to instruction memory
- IMEM_ADDRESS  out  32  word address of request; stable while IMEM_READ=1
- IMEM_READDATA  in  32  read data; valid in any cycle where IMEM_READ=1 and IMEM_BUSYWAIT=0
- IMEM_BUSYWAIT  in  1  memory not ready; request completes at first edge with IMEM_READ=1, BUSYWAIT=0
- INSTRUCTION  out  32  buffered instruction, registered
- PC  out  32  address of INSTRUCTION, registered
- PC_PLUS_4  out  32  PC+4 (mod 2^32), registered
- FETCH_VALID  out  1  outputs hold a real instruction

## Operation
- Internal state: pc_reg (next fetch address); output buffer (INSTRUCTION/PC/PC_PLUS_4/FETCH_VALID); one-entry skid register; FSM {IDLE, REQ, HOLD}.
- IDLE: IMEM_READ=0. Next edge goes to REQ.
- REQ: IMEM_READ=1, IMEM_ADDRESS=pc_reg. A completion is an edge where IMEM_BUSYWAIT=0.
  - Completion with buffer free (FETCH_VALID=0 or STALL=0): load buffer {IMEM_READDATA, pc_reg, pc_reg+4, 1}, pc_reg+=4, stay in REQ.
  - Completion with buffer blocked (FETCH_VALID=1 and STALL=1): capture into skid, pc_reg+=4, go to HOLD.
  - No completion, STALL=0: buffer consumed; FETCH_VALID<=0, INSTRUCTION<=NOP_INSTR, PC/PC_PLUS_4 unchanged.
  - No completion, STALL=1: buffer unchanged.
- HOLD: IMEM_READ=0. Buffer unchanged while STALL=1. At the first edge with STALL=0, the skid moves into the buffer and the FSM goes to REQ.
- Redirect (BRANCH_TAKEN=1 at an edge, any state, regardless of STALL):
  - pc_reg<={BRANCH_TARGET[31:2],2'b00}
  - buffer and skid invalidated (FETCH_VALID<=0, INSTRUCTION<=NOP_INSTR)
  - any completion at that edge is discarded
  - FSM goes to IDLE, giving one dead cycle so memory drops the old request.
- Priority: RESET > BRANCH_TAKEN > STALL > normal.
- Arithmetic: all PC adds are 32-bit modulo. 0xFFFFFFFC+4 = 0x00000000, with no flag.
- IMEM_ADDRESS equals pc_reg at all times. It changes only on completion or redirect.

## Timing
- Reset values:
  - pc_reg=RESET_PC, FSM=IDLE
  - INSTRUCTION=NOP_INSTR, PC=0, PC_PLUS_4=0, FETCH_VALID=0
  - IMEM_READ=0, skid empty
- Reset mid-request: abandoned immediately. IMEM_READ=0 in the cycle after the reset edge.
- Startup: let E0 be the last edge sampled with RESET=1. At E1, IDLE→REQ. At E2, with zero-wait memory, FETCH_VALID=1 and PC=RESET_PC.
- Throughput: one instruction per cycle with zero-wait memory and STALL=0. Each BUSYWAIT cycle adds one bubble.
- Redirect latency: for BRANCH_TAKEN at edge B, the target is fetched in cycle B+1..B+2 and appears on the outputs after B+2 (zero wait). Two bubble cycles.
- Outputs are fully registered. No combinational path from STALL or BRANCH_TAKEN to the outputs. IMEM_READ depends only on FSM state.
- No instruction is lost or duplicated across any stall length, including a stall that begins on a completion edge.

## Test plan
- Reset then zero-wait memory returning addr-tagged words (data=0xA0000000|addr): after E2, one instruction per cycle with PC=0,4,8… and PC_PLUS_4=PC+4; FETCH_VALID stays 1.
- Memory with BUSYWAIT=1 for 2 cycles per read: FETCH_VALID pattern 1,0,0 repeating; IMEM_ADDRESS stable during busywait; no PC skipped.
- STALL=1 for 3 cycles starting on a completion edge at PC=0x10: outputs hold PC=0x10, FSM enters HOLD with 0x14 in skid, IMEM_READ=0; after release, PC=0x14 then 0x18, no gaps or repeats.
- BRANCH_TAKEN with target 0x00000102 while busywait pending and STALL=1: next edge FETCH_VALID=0 and INSTRUCTION=0x00000013, one IMEM_READ=0 cycle, then IMEM_ADDRESS=0x00000100; the old data is never presented.
- RESET_PC=0xFFFFFFF8, zero wait: PC sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; PC_PLUS_4 for 0xFFFFFFFC is 0x00000000.
- RESET asserted while in HOLD with FETCH_VALID=1: next edge gives all outputs at reset values and an empty skid; the fetch restarts at RESET_PC.
